// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: rotates a one-cold row drive, snapshots
// the whole keypad once per frame, debounces snapshots and emits key press events.
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] COLUMN,
    output logic [3:0] ROW,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic {S_IDLE, S_PRESSED} state_t;

    logic [3:0]    r_col_s1, r_col_s2;
    logic [DW-1:0] r_div;
    logic [1:0]    r_row;
    logic [15:0]   r_snap, r_prev;
    logic [CW-1:0] r_stable;
    state_t        r_state;
    logic [3:0]    r_code;
    logic          r_valid, r_down;

    logic          w_last, w_frame_end, w_none, w_single, w_accept;
    logic [3:0]    w_sample, w_key;
    logic [15:0]   w_frame;
    logic [CW-1:0] w_stable_nx;

    assign w_last      = (r_div == DW'(SCAN_DIV - 1));
    assign w_frame_end = w_last && (r_row == 2'd3);
    assign w_sample    = ~r_col_s2;
    // Row 3 is sampled on the frame-end edge, so it bypasses the snapshot register.
    assign w_frame     = {w_sample, r_snap[11:0]};
    assign w_none      = (w_frame == 16'd0);
    assign w_single    = !w_none && ((w_frame & (w_frame - 16'd1)) == 16'd0);

    always_comb begin
        w_key = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (w_frame[i]) w_key = 4'(i);
    end

    always_comb begin
        w_stable_nx = CW'(1);
        if (w_frame == r_prev)
            w_stable_nx = (r_stable == CW'(DEBOUNCE)) ? r_stable : r_stable + CW'(1);
    end

    assign w_accept = w_frame_end && (w_stable_nx == CW'(DEBOUNCE));

    // Synchronizer idles at all-ones (no key) so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
            r_div    <= '0;
            r_row    <= 2'd0;
            r_snap   <= '0;
            r_prev   <= '0;
            r_stable <= '0;
        end else begin
            r_col_s1 <= COLUMN;
            r_col_s2 <= r_col_s1;
            if (w_last) begin
                r_div               <= '0;
                r_row               <= r_row + 2'd1;
                r_snap[4*r_row +: 4] <= w_sample;
                if (w_frame_end) begin
                    r_prev   <= w_frame;
                    r_stable <= w_stable_nx;
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_code  <= 4'd0;
            r_valid <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_IDLE: if (w_single) begin
                        r_code  <= w_key;
                        r_valid <= 1'b1;
                        r_down  <= 1'b1;
                        r_state <= S_PRESSED;
                    end
                    S_PRESSED: if (w_none) begin
                        r_down  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_single && (w_key != r_code)) begin
                        r_code  <= w_key;
                        r_valid <= 1'b1;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ROW       = ~(4'b0001 << r_row);
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_down  = r_down;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3 (16-cycle frames)
// and a behavioural keypad that pulls columns low for pressed keys on the driven row.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid, key_down;
    logic [15:0] pressed = 16'd0;

    int n_chk = 0, n_fail = 0;
    int pulses = 0, falls = 0;
    logic prev_down = 1'b0;
    int p0, f0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst_n(rst_n), .COLUMN(col), .ROW(row),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[4*r+c] && !row[r]) col[c] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid) pulses++;
        if (prev_down && !key_down) falls++;
        prev_down = key_down;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * 16) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_row;
        // Reset state and row rotation timing
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_row", row, 4'b1110);
        chk("rst_code", key_code, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_down", key_down, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            exp_row = 4'b1110;
            if (k >= 4)  exp_row = 4'b1101;
            if (k >= 8)  exp_row = 4'b1011;
            if (k >= 12) exp_row = 4'b0111;
            if (k >= 16) exp_row = 4'b1110;
            if (k == 3 || k == 4 || k == 8 || k == 12 || k == 16)
                chk($sformatf("row_edge%0d", k), row, exp_row);
        end
        frames(3);

        // Bounce on key 9 (toggle every 5 cycles)
        p0 = pulses;
        for (int t = 0; t < 19; t++) begin
            pressed = (t % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (5) @(posedge clk);
        end
        pressed = 16'h0000;
        frames(5);
        chk("bounce_pulses", pulses - p0, 0);
        chk("bounce_code", key_code, 0);
        chk("bounce_down", key_down, 0);

        // Clean press of key 6 (row 1, col 2)
        p0 = pulses;
        pressed = 16'h0040;
        frames(10);
        chk("press_pulses", pulses - p0, 1);
        chk("press_code", key_code, 6);
        chk("press_down", key_down, 1);
        pressed = 16'h0000;
        frames(1);
        chk("release_down_early", key_down, 1);
        frames(4);
        chk("release_down", key_down, 0);
        chk("release_pulses", pulses - p0, 1);

        // Multi-key from idle, then extra key while key 3 held
        p0 = pulses;
        pressed = 16'h8001;
        frames(8);
        chk("multi_pulses", pulses - p0, 0);
        chk("multi_down", key_down, 0);
        pressed = 16'h0000;
        frames(4);
        pressed = 16'h0008;
        frames(5);
        chk("k3_pulses", pulses - p0, 1);
        chk("k3_code", key_code, 3);
        pressed = 16'h0088;
        frames(5);
        chk("k3k7_pulses", pulses - p0, 1);
        chk("k3k7_down", key_down, 1);
        chk("k3k7_code", key_code, 3);

        // Direct change 3 -> 12 without release
        pressed = 16'h0008;
        frames(4);
        p0 = pulses;
        f0 = falls;
        pressed = 16'h1000;
        frames(2);
        chk("chg_early_pulses", pulses - p0, 0);
        frames(3);
        chk("chg_pulses", pulses - p0, 1);
        chk("chg_code", key_code, 12);
        chk("chg_no_fall", falls - f0, 0);
        chk("chg_down", key_down, 1);
        pressed = 16'h0000;
        frames(5);
        chk("chg_release", key_down, 0);

        // Reset two frames into a key 5 press, key kept held
        p0 = pulses;
        pressed = 16'h0020;
        frames(2);
        chk("mid_pre_pulses", pulses - p0, 0);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_row", row, 4'b1110);
        chk("mid_rst_code", key_code, 0);
        chk("mid_rst_valid", key_valid, 0);
        chk("mid_rst_down", key_down, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 1; k <= 49; k++) begin
            @(posedge clk);
            #1;
            if (k == 47) begin
                chk("mid_valid_e47", key_valid, 0);
                chk("mid_down_e47", key_down, 0);
            end
            if (k == 48) begin
                chk("mid_valid_e48", key_valid, 1);
                chk("mid_code_e48", key_code, 5);
                chk("mid_down_e48", key_down, 1);
            end
            if (k == 49) chk("mid_valid_e49", key_valid, 0);
        end
        pressed = 16'h0000;
        frames(5);
        chk("mid_total_pulses", pulses - p0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
